// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package key_debounce_pkg;

  // Per-channel debounce state. The wait states count stable samples
  // toward accepting a change.
  typedef enum logic [1:0] {
    ST_UP,
    ST_WAIT_DOWN,
    ST_DOWN,
    ST_WAIT_UP
  } deb_state_e;

  // 5 ms at a 50 MHz system clock.
  localparam int DEBOUNCE_5MS_50MHZ = 250000;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter and a
// hysteretic 4-state FSM producing a clean level plus press/release pulses.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             s;
  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;

  // Synchronize the inverted key so that 1 means pressed; resets to released.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ~i_key_n};
    end
  end

  assign s = sync_q[1];

  // Debounce FSM with counter and registered edge pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_UP;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        ST_UP: begin
          if (s) begin
            state_q <= ST_WAIT_DOWN;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_WAIT_DOWN: begin
          if (!s) begin
            // Glitch: fall back silently.
            state_q <= ST_UP;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= ST_DOWN;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DOWN: begin
          if (!s) begin
            state_q <= ST_WAIT_UP;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_WAIT_UP: begin
          if (s) begin
            state_q <= ST_DOWN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q   <= ST_UP;
            cnt_q     <= '0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_UP;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Level stays high through the release wait, so bounces never toggle it.
  assign o_pressed       = (state_q == ST_DOWN) || (state_q == ST_WAIT_UP);
  assign o_press_pulse   = press_q;
  assign o_release_pulse = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounce and edge-pulse block for N_KEYS active-low push buttons.
// Key 0's press pulse is the start strobe for the random generator.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key_n,
  output logic [N_KEYS-1:0] o_pressed,
  output logic [N_KEYS-1:0] o_press_pulse,
  output logic [N_KEYS-1:0] o_release_pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  if (N_KEYS < 1) begin : g_bad_keys
    $error("key_debounce: N_KEYS must be >= 1");
  end

  // One fully independent channel per key.
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_key_n        (i_key_n[g]),
      .o_pressed      (o_pressed[g]),
      .o_press_pulse  (o_press_pulse[g]),
      .o_release_pulse(o_release_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce with a run-length reference
// model feeding an event scoreboard.
module tb_key_debounce;

  localparam int D = 8;
  localparam int N = 4;
  localparam int LAT = D + 2;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [N-1:0] i_key_n = '1;
  logic [N-1:0] o_pressed;
  logic [N-1:0] o_press_pulse;
  logic [N-1:0] o_release_pulse;

  key_debounce #(
    .N_KEYS         (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_key_n        (i_key_n),
    .o_pressed      (o_pressed),
    .o_press_pulse  (o_press_pulse),
    .o_release_pulse(o_release_pulse)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int cyc;
    int ch;
    bit rel;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  cyc = 0;

  // Reference model: raw key seen through a 2-cycle delay; a change is
  // accepted once the delayed value has differed from the level for D+1
  // consecutive clock samples.
  logic [N-1:0] m_d1 = '0;
  logic [N-1:0] m_d2 = '0;
  logic [N-1:0] m_lvl = '0;
  int           m_run[N];

  int last_press[N];
  int last_rel[N];
  int n_press[N];
  int n_rel[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    for (int ch = 0; ch < N; ch++) m_run[ch] = 0;
    forever begin
      @(posedge i_clk or posedge i_rst);
      if (i_rst) begin
        m_d1  = '0;
        m_d2  = '0;
        m_lvl = '0;
        for (int ch = 0; ch < N; ch++) m_run[ch] = 0;
      end else begin
        cyc++;
        for (int ch = 0; ch < N; ch++) begin
          logic s;
          s         = m_d2[ch];
          m_d2[ch]  = m_d1[ch];
          m_d1[ch]  = ~i_key_n[ch];
          if (s != m_lvl[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == D + 1) begin
              m_lvl[ch] = s;
              m_run[ch] = 0;
              exp_q.push_back('{cyc: cyc, ch: ch, rel: !s});
            end
          end else begin
            m_run[ch] = 0;
          end
        end
      end
    end
  end

  task automatic take_pulse(input int ch, input bit rel);
    ev_t ev;
    if (exp_q.size() == 0) begin
      check(rel ? "unexpected_release" : "unexpected_press", 32'(ch), 32'hffff_ffff);
    end else begin
      ev = exp_q.pop_front();
      check("pulse_cycle", 32'(cyc), 32'(ev.cyc));
      check("pulse_channel", 32'(ch), 32'(ev.ch));
      check("pulse_kind", 32'(rel), 32'(ev.rel));
    end
    if (rel) begin
      last_rel[ch] = cyc;
      n_rel[ch]++;
    end else begin
      last_press[ch] = cyc;
      n_press[ch]++;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    for (int ch = 0; ch < N; ch++) begin
      last_press[ch] = -1;
      last_rel[ch]   = -1;
      n_press[ch]    = 0;
      n_rel[ch]      = 0;
    end
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        check("outputs_in_reset", 32'({o_pressed, o_press_pulse, o_release_pulse}), 32'd0);
      end else begin
        check("pressed_level", 32'(o_pressed), 32'(m_lvl));
        for (int ch = 0; ch < N; ch++) begin
          if (o_press_pulse[ch] && o_release_pulse[ch]) begin
            check("pulses_coincide", 32'(ch), 32'hffff_ffff);
          end
          if (o_press_pulse[ch]) take_pulse(ch, 1'b0);
          if (o_release_pulse[ch]) take_pulse(ch, 1'b1);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          check("missed_pulse_cycle", 32'hffff_ffff, 32'(exp_q[0].cyc));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    int t0, t1, np, nr;
    int run_left[N];

    // Keys held through reset: reported together once reset is released.
    i_key_n = '0;
    cycles(3);
    i_rst = 1'b0;
    t0 = cyc + 1;
    cycles(LAT + 4);
    for (int ch = 0; ch < N; ch++) check("held_through_reset_lat", 32'(last_press[ch]), 32'(t0 + LAT));
    i_key_n = '1;
    cycles(LAT + 4);

    // Clean press and release on key 0.
    np = n_press[0];
    nr = n_rel[0];
    i_key_n[0] = 1'b0;
    t0 = cyc + 1;
    cycles(20);
    i_key_n[0] = 1'b1;
    t1 = cyc + 1;
    cycles(LAT + 4);
    check("clean_press_lat", 32'(last_press[0]), 32'(t0 + LAT));
    check("clean_release_lat", 32'(last_rel[0]), 32'(t1 + LAT));
    check("clean_press_count", 32'(n_press[0] - np), 32'd1);
    check("clean_release_count", 32'(n_rel[0] - nr), 32'd1);

    // Bounce on key 1 every 3 cycles, then a final fall.
    np = n_press[1];
    for (int k = 0; k < 14; k++) begin
      i_key_n[1] = k[0];
      cycles(3);
    end
    check("bounce_no_pulse", 32'(n_press[1] - np), 32'd0);
    i_key_n[1] = 1'b0;
    t0 = cyc + 1;
    cycles(LAT + 4);
    check("bounce_final_press_lat", 32'(last_press[1]), 32'(t0 + LAT));
    check("bounce_press_count", 32'(n_press[1] - np), 32'd1);
    i_key_n[1] = 1'b1;
    cycles(LAT + 4);

    // Threshold on key 2: one sample short of acceptance, then exactly enough.
    np = n_press[2];
    i_key_n[2] = 1'b0;
    cycles(D);
    i_key_n[2] = 1'b1;
    cycles(LAT + 4);
    check("threshold_short_no_pulse", 32'(n_press[2] - np), 32'd0);
    i_key_n[2] = 1'b0;
    t0 = cyc + 1;
    cycles(D + 1);
    i_key_n[2] = 1'b1;
    t1 = cyc + 1;
    cycles(LAT + 4);
    check("threshold_exact_press_count", 32'(n_press[2] - np), 32'd1);
    check("threshold_exact_press_lat", 32'(last_press[2]), 32'(t0 + LAT));
    check("threshold_release_lat", 32'(last_rel[2]), 32'(t1 + LAT));

    // Reset while key 3 is held: asynchronous clear, no release pulse.
    i_key_n[3] = 1'b0;
    cycles(LAT + 4);
    check("hold_before_reset", 32'(o_pressed[3]), 32'd1);
    nr = n_rel[3];
    #1 i_rst = 1'b1;
    #1 check("async_reset_clear", 32'({o_pressed, o_press_pulse, o_release_pulse}), 32'd0);
    cycles(1);
    i_rst = 1'b0;
    t0 = cyc + 1;
    cycles(LAT + 4);
    check("reset_no_release", 32'(n_rel[3] - nr), 32'd0);
    check("repress_after_reset_lat", 32'(last_press[3]), 32'(t0 + LAT));
    i_key_n[3] = 1'b1;
    cycles(LAT + 4);

    // Staggered presses on keys 0 and 1.
    i_key_n[0] = 1'b0;
    cycles(3);
    i_key_n[1] = 1'b0;
    cycles(LAT + 4);
    check("stagger_gap", 32'(last_press[1] - last_press[0]), 32'd3);
    i_key_n[1:0] = 2'b11;
    cycles(LAT + 4);

    // Random bouncing on all keys, checked by the scoreboard.
    for (int ch = 0; ch < N; ch++) run_left[ch] = $urandom_range(1, 14);
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < N; ch++) begin
        run_left[ch]--;
        if (run_left[ch] == 0) begin
          i_key_n[ch] = ~i_key_n[ch];
          run_left[ch] = $urandom_range(1, 14);
        end
      end
      cycles(1);
    end
    i_key_n = '1;
    cycles(2 * LAT + 4);
    check("final_released", 32'(o_pressed), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
